referee_merge: RTL and testbench

REFEREE_MERGE -- requirements
Module: referee_merge

---
 rtl/referee_merge_pkg.sv | 9 +
 rtl/referee_merge_arb_rr_select.sv | 16 +
 rtl/referee_merge.sv | 64 ++++++
 tb/tb_referee_merge.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/referee_merge_pkg.sv
// referee_merge_pkg: shared state enum, source count and default word/field widths
package referee_merge_pkg;
  localparam int NUM_SRC = 4;
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int LINE_SIZE_DEF = 12;
  localparam int CLASS_BITS_DEF = 2;
  localparam int DEST_BITS_DEF = 2;
  typedef enum logic [1:0] {IDLE, POP, READ, PUSH} state_t;
endpackage

// File: rtl/referee_merge_arb_rr_select.sv
// arb_rr_select: picks the first set mask bit at or after start, wrapping around
module arb_rr_select
  import referee_merge_pkg::*;
(
  input  logic [NUM_SRC-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);
  always_comb begin
    grant = start;
    valid = |mask;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (mask[IDX_W'(int'(start) + k)]) grant = IDX_W'(int'(start) + k);
  end
endmodule

// File: rtl/referee_merge.sv
// referee_merge: 4-to-1 FIFO merger, one word per IDLE/POP/READ/PUSH transfer.
// Define REFEREE_MERGE_STRICT_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module referee_merge
  import referee_merge_pkg::*;
#(
  parameter int LINE_SIZE  = LINE_SIZE_DEF,
  parameter int CLASS_BITS = CLASS_BITS_DEF,
  parameter int DEST_BITS  = DEST_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC*LINE_SIZE-1:0] data_in,
  input  logic [NUM_SRC-1:0]           almost_empty_signal,
  input  logic                         almost_full_signal,
  output logic [NUM_SRC-1:0]           pop_signal,
  output logic                         push_signal,
  output logic [LINE_SIZE-1:0]         data_out,
  output logic [IDX_W-1:0]             grant_id
);
  if (CLASS_BITS + DEST_BITS > LINE_SIZE) begin : g_bad_fields
    $error("class and dest fields do not fit in LINE_SIZE");
  end
  state_t state, state_n;
  logic [IDX_W-1:0] start, grant;
  logic valid, take;
  arb_rr_select u_arb (
    .mask  (~almost_empty_signal),
    .start (start),
    .grant (grant),
    .valid (valid)
  );
  assign take = (state == IDLE) && valid && !almost_full_signal;
`ifdef REFEREE_MERGE_STRICT_PRIORITY_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] ptr;
  // pointer resets to the last index so the first search begins at source 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= IDX_W'(NUM_SRC - 1);
    else if (take) ptr <= grant;
  assign start = ptr + 1'b1;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (take ? POP : IDLE) :
              (state == POP)  ? READ :
              (state == READ) ? PUSH : IDLE;
  end
  // source data appears one cycle after its pop, so it is captured leaving READ
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pop_signal  <= '0;
      push_signal <= 1'b0;
      data_out    <= '0;
      grant_id    <= '0;
    end else begin
      pop_signal  <= take ? NUM_SRC'(1) << grant : '0;
      push_signal <= state == READ;
      if (take) grant_id <= grant;
      if (state == READ) data_out <= data_in[grant_id*LINE_SIZE +: LINE_SIZE];
    end
endmodule

// File: tb/tb_referee_merge.sv
// tb_referee_merge: table vectors, corner sequences and random traffic against a transaction model
module tb_referee_merge;
  localparam int LS = 12;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4*LS-1:0] data_in = '0;
  logic [3:0] almost_empty_signal = 4'hF;
  logic almost_full_signal = 1'b0;
  logic [3:0] pop_signal;
  logic push_signal;
  logic [LS-1:0] data_out;
  logic [1:0] grant_id;
  int vectors = 0, miscompares = 0;
  int busy, g, last, pops, pushes;
  logic [3:0] e_pop;
  logic e_push;
  logic [LS-1:0] e_data;
  logic [1:0] e_gid;
  int grants[$];

  referee_merge #(.LINE_SIZE(LS), .CLASS_BITS(2), .DEST_BITS(2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .almost_empty_signal(almost_empty_signal), .almost_full_signal(almost_full_signal),
    .pop_signal(pop_signal), .push_signal(push_signal),
    .data_out(data_out), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ae; logic af;
    logic [3:0] pop; logic push; logic [LS-1:0] data; logic [1:0] gid;
  } vec_t;
  vec_t tbl[13];

  task automatic compare(string name, logic [3:0] p, logic ps, logic [LS-1:0] d, logic [1:0] gi);
    vectors++;
    if (pop_signal !== p || push_signal !== ps || data_out !== d || grant_id !== gi) begin
      miscompares++;
      $display("FAIL %s: got pop=%b push=%b data=%h gid=%0d, want pop=%b push=%b data=%h gid=%0d",
               name, pop_signal, push_signal, data_out, grant_id, p, ps, d, gi);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void model_reset();
    busy = 0; last = 3; g = 0;
    e_pop = '0; e_push = 1'b0; e_data = '0; e_gid = '0;
  endfunction

  // busy counts the cycles left in a transfer once it has been granted
  function automatic void model_edge();
    if (busy == 0) begin
      e_pop = '0; e_push = 1'b0;
      if (!almost_full_signal && almost_empty_signal != 4'hF) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
`ifdef REFEREE_MERGE_STRICT_PRIORITY_EN
          c = k - 1;
`else
          c = (last + k) % 4;
`endif
          if (!almost_empty_signal[c]) begin g = c; break; end
        end
        last = g; e_gid = 2'(g); e_pop = 4'b1 << g; busy = 3;
      end
    end else if (busy == 3) begin
      e_pop = '0; busy = 2;
    end else if (busy == 2) begin
      e_data = data_in[g*LS +: LS]; e_push = 1'b1; busy = 1;
    end else begin
      e_push = 1'b0; busy = 0;
    end
  endfunction

  task automatic step(string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(name, e_pop, e_push, e_data, e_gid);
    if (|pop_signal) pops++;
    if (push_signal) pushes++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    compare("reset", e_pop, e_push, e_data, e_gid);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 1'b0, 4'b0001, 1'b0, 12'h000, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 12'hA5C, 2'd0};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 12'hA5C, 2'd0};
    tbl[4]  = '{4'b1101, 1'b1, 4'b0000, 1'b0, 12'hA5C, 2'd0};
    tbl[5]  = '{4'b1101, 1'b0, 4'b0010, 1'b0, 12'hA5C, 2'd1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 12'hA5C, 2'd1};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 12'h3C1, 2'd1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 12'h3C1, 2'd1};
    tbl[9]  = '{4'b1011, 1'b0, 4'b0100, 1'b0, 12'h3C1, 2'd2};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 12'h3C1, 2'd2};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 12'h7E2, 2'd2};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 12'h7E2, 2'd2};
    model_reset();
    #1;
    compare("por", '0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;

    data_in = {12'hF03, 12'h7E2, 12'h3C1, 12'hA5C};
    for (int i = 0; i < 13; i++) begin
      almost_empty_signal = tbl[i].ae;
      almost_full_signal = tbl[i].af;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare($sformatf("tbl%0d", i), tbl[i].pop, tbl[i].push, tbl[i].data, tbl[i].gid);
    end

    // fairness: every source always eligible for 16 transfers
    do_reset();
    almost_empty_signal = 4'b0000;
    almost_full_signal = 1'b0;
    repeat (64) begin
      step("rr");
      if (|pop_signal) grants.push_back(int'(grant_id));
    end
    check_val("rr_count", grants.size(), 16);
    foreach (grants[k]) begin
`ifdef REFEREE_MERGE_STRICT_PRIORITY_EN
      check_val($sformatf("rr_grant%0d", k), grants[k], 0);
`else
      check_val($sformatf("rr_grant%0d", k), grants[k], k % 4);
`endif
    end

    // backpressure held in IDLE, then released
    do_reset();
    almost_full_signal = 1'b1;
    repeat (10) step("bp_hold");
    almost_full_signal = 1'b0;
    step("bp_release");
    check_val("bp_first_pop", int'(pop_signal), 1);
    almost_empty_signal = 4'hF;
    repeat (3) step("bp_drain");

    // reset asserted while in READ
    do_reset();
    almost_empty_signal = 4'b1110;
    step("mr_pop");
    almost_empty_signal = 4'b1111;
    step("mr_read");
    reset = 1'b0;
    #1;
    model_reset();
    compare("mr_async", '0, 1'b0, '0, '0);
    repeat (2) begin
      @(negedge clk);
      compare("mr_held", '0, 1'b0, '0, '0);
    end
    reset = 1'b1;
    step("mr_idle");
    almost_empty_signal = 4'b1110;
    step("mr_resume");

    // random traffic
    do_reset();
    pops = 0;
    pushes = 0;
    repeat (1000) begin
      almost_empty_signal = 4'($urandom);
      almost_full_signal = ($urandom_range(3) == 0);
      data_in = {16'($urandom), $urandom};
      step("rand");
    end
    check_val("pop_push_balance", int'((pops - pushes) >= 0 && (pops - pushes) <= 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
